// File: rtl/postddr_64to18_converter.sv
// ---------------------------------------------------------------------------
// postddr_64to18_converter
//
// Unpacks 64-bit words from the post-DDR FIFO into a stream of samples. In
// 18-bit mode each sample is 18 bits. In 8-bit mode each sample is 8 bits
// and is zero-extended to 18 bits. Within a word the first sample sits in
// the MSBs, and samples may straddle word boundaries. A 100-bit MSB-justified
// staging buffer holds the bits that have not been emitted yet.
//
// Ports:
//   wr_clk        sole clock, rising edge
//   reset         synchronous active-high reset
//   enabled       block enable; low forces IDLE and clears the datapath
//   start         one-cycle pulse: clear datapath, load mode/count, enter RUN
//   I_4bit_mode   1 = 8-bit samples, 0 = 18-bit samples (sampled on start)
//   num_samples   samples to emit, 0 = unlimited (sampled on start)
//   word_din      packed input word, first sample in MSBs
//   word_valid    word_din valid
//   word_ready    word accepted when word_valid && word_ready
//   sample_dout   current sample (zero when sample_valid is low)
//   sample_valid  sample_dout valid
//   sample_ready  sample taken when sample_valid && sample_ready
//   done          one-cycle pulse after the last requested sample is taken
//   busy          high while in RUN
//   samples_out   samples taken since the last start (saturating)
// ---------------------------------------------------------------------------
module postddr_64to18_converter #(
  parameter int pCOUNT_WIDTH = 32
) (
  input  logic                    wr_clk,
  input  logic                    reset,
  input  logic                    enabled,
  input  logic                    start,
  input  logic                    I_4bit_mode,
  input  logic [pCOUNT_WIDTH-1:0] num_samples,
  input  logic [63:0]             word_din,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic [17:0]             sample_dout,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    done,
  output logic                    busy,
  output logic [pCOUNT_WIDTH-1:0] samples_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                  r_state;
  logic [99:0]             r_buf;
  logic [6:0]              r_fill;
  logic                    r_mode;
  logic [pCOUNT_WIDTH-1:0] r_count;
  logic [pCOUNT_WIDTH-1:0] r_samples;

  logic [6:0]              w_width;
  logic                    w_valid;
  logic                    w_ready;
  logic                    w_take;
  logic                    w_accept;
  logic [6:0]              w_fill_after_take;
  logic [99:0]             w_buf_after_take;
  logic [99:0]             w_word_placed;
  logic [99:0]             w_buf_next;
  logic [6:0]              w_fill_next;
  logic [pCOUNT_WIDTH-1:0] w_samples_inc;
  logic                    w_last;

  assign w_width = r_mode ? 7'd8 : 7'd18;

  // Handshake qualifiers depend only on registered state, never on inputs.
  assign w_valid  = (r_state == ST_RUN) && (r_fill >= w_width);
  // Accept only below 2W, so the buffer can never exceed 35 + 64 = 99 bits.
  assign w_ready  = (r_state == ST_RUN) && (r_fill < (r_mode ? 7'd16 : 7'd36));
  assign w_take   = w_valid && sample_ready;
  assign w_accept = word_valid && w_ready;

  // A take is applied first. The incoming word is then appended directly
  // below the remaining valid bits. Bits below the valid region are always
  // zero, so an OR is enough to merge the word.
  assign w_fill_after_take = r_fill - (w_take ? w_width : 7'd0);
  assign w_buf_after_take  = !w_take ? r_buf :
                             (r_mode ? {r_buf[91:0], 8'b0} : {r_buf[81:0], 18'b0});
  assign w_word_placed     = {word_din, 36'b0} >> w_fill_after_take;
  assign w_buf_next        = w_buf_after_take | (w_accept ? w_word_placed : 100'b0);
  assign w_fill_next       = w_fill_after_take + (w_accept ? 7'd64 : 7'd0);

  assign w_samples_inc = (&r_samples) ? r_samples : r_samples + 1'b1;
  assign w_last        = w_take && (r_count != '0) && (w_samples_inc == r_count);

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_buf     <= '0;
      r_fill    <= '0;
      r_mode    <= 1'b0;
      r_count   <= '0;
      r_samples <= '0;
    end else if (!enabled) begin
      r_state   <= ST_IDLE;
      r_buf     <= '0;
      r_fill    <= '0;
      r_samples <= '0;
    end else if (start) begin
      // Start overrides any transfer in the same cycle; that transfer is dropped.
      r_state   <= ST_RUN;
      r_buf     <= '0;
      r_fill    <= '0;
      r_samples <= '0;
      r_mode    <= I_4bit_mode;
      r_count   <= num_samples;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_buf  <= w_buf_next;
          r_fill <= w_fill_next;
          if (w_take)
            r_samples <= w_samples_inc;
          if (w_last) begin
            // Whatever is left in the buffer is filler and is thrown away.
            r_state <= ST_DONE;
            r_buf   <= '0;
            r_fill  <= '0;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign word_ready   = w_ready;
  assign sample_valid = w_valid;
  assign sample_dout  = !w_valid ? 18'd0 :
                        (r_mode ? {10'b0, r_buf[99:92]} : r_buf[99:82]);
  assign done         = (r_state == ST_DONE);
  assign busy         = (r_state == ST_RUN);
  assign samples_out  = r_samples;

endmodule
